// File: rtl/sort_pkg.sv
// Shared types for the insertion sorter: FSM encoding, the cell entry record and the ordering rule.
// Entries are held at the maximum supported width and zero-extended, so DATA_WIDTH <= 32 and ADDR_WIDTH <= 16.
package sort_pkg;

  localparam int unsigned SORT_MAX_DW = 32;
  localparam int unsigned SORT_MAX_AW = 16;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } sort_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SORT_MAX_DW-1:0] count;
    logic [SORT_MAX_AW-1:0] addr;
  } sort_entry_t;

  // True when a stored count stays ahead of (or ties) a new count; ties keep arrival order.
  function automatic logic sort_precedes(input logic [SORT_MAX_DW-1:0] stored,
                                         input logic [SORT_MAX_DW-1:0] incoming,
                                         input logic                   desc);
    return desc ? (stored >= incoming) : (stored <= incoming);
  endfunction

endpackage

// File: rtl/insertion_sorter_if.sv
// Load/readout bus of the insertion sorter; master is the producer/consumer, slave is the sorter.
interface insertion_sorter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 10
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_count;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  drain_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_count;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [OCC_W-1:0]      occupancy;
  logic                  full;
  logic                  empty;

  modport master (
    output clear, in_valid, in_count, in_addr, drain_req, out_ready,
    input  in_ready, out_valid, out_count, out_addr, occupancy, full, empty
  );

  modport slave (
    input  clear, in_valid, in_count, in_addr, drain_req, out_ready,
    output in_ready, out_valid, out_count, out_addr, occupancy, full, empty
  );

endinterface

// File: rtl/sort_cell.sv
// One sort position: keeps, takes the new entry or takes its upstream neighbour on insert;
// takes its downstream neighbour on a readout shift.
module sort_cell
  import sort_pkg::*;
#(
  parameter bit DESCENDING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        insert,
  input  logic        shift,
  input  sort_entry_t new_entry,
  input  sort_entry_t prev_entry,
  input  logic        prev_keep,
  input  sort_entry_t next_entry,
  output sort_entry_t entry,
  output logic        keep_c
);

  // An empty cell never stays ahead of a real entry, so empties always sink to the tail.
  assign keep_c = entry.valid && sort_precedes(entry.count, new_entry.count, DESCENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (clear) begin
      entry <= '0;
    end else if (insert) begin
      if (!keep_c) entry <= prev_keep ? new_entry : prev_entry;
    end else if (shift) begin
      entry <= next_entry;
    end
  end

endmodule

// File: rtl/insertion_sorter.sv
// Stable insertion sorter: entries are sorted on arrival into a chain of cells, then read out
// head-first after a drain request.
module insertion_sorter
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 10,
  parameter bit          DESCENDING = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  insertion_sorter_if.slave sif
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  sort_state_t      state_q, state_d;
  logic [OCC_W-1:0] occ_q;
  logic             full_c, ready_c, out_valid_c, accept, consume;
  sort_entry_t      new_entry;
  sort_entry_t      cell_entry  [DEPTH];
  logic             cell_keep_c [DEPTH];

  assign full_c      = (occ_q == OCC_W'(DEPTH));
  assign ready_c     = (state_q == ST_FILL) && !full_c;
  assign out_valid_c = (state_q == ST_DRAIN) && cell_entry[0].valid;
  assign accept      = sif.in_valid && ready_c;
  assign consume     = out_valid_c && sif.out_ready;

  assign new_entry = '{valid: 1'b1,
                       count: SORT_MAX_DW'(sif.in_count),
                       addr:  SORT_MAX_AW'(sif.in_addr)};

  assign sif.in_ready  = ready_c;
  assign sif.out_valid = out_valid_c;
  assign sif.out_count = out_valid_c ? DATA_WIDTH'(cell_entry[0].count) : '0;
  assign sif.out_addr  = out_valid_c ? ADDR_WIDTH'(cell_entry[0].addr) : '0;
  assign sif.occupancy = occ_q;
  assign sif.full      = full_c;
  assign sif.empty     = (occ_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // A drain request accompanied by an accept still counts when the chain was empty.
  always_comb begin
    state_d = state_q;
    if (sif.clear) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL:  if (sif.drain_req && ((occ_q != '0) || accept)) state_d = ST_DRAIN;
        ST_DRAIN: if (consume && (occ_q == OCC_W'(1)))            state_d = ST_FILL;
        default:  state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        occ_q <= '0;
    else if (sif.clear) occ_q <= '0;
    else if (accept)   occ_q <= occ_q + OCC_W'(1);
    else if (consume)  occ_q <= occ_q - OCC_W'(1);
  end

  // Cell 0 sees a virtual upstream cell that always keeps; the tail shifts in an empty entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sort_entry_t prev_e, next_e;
    logic        prev_k;

    if (i == 0) begin : g_first
      assign prev_e = '0;
      assign prev_k = 1'b1;
    end else begin : g_up
      assign prev_e = cell_entry[i-1];
      assign prev_k = cell_keep_c[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign next_e = '0;
    end else begin : g_down
      assign next_e = cell_entry[i+1];
    end

    sort_cell #(.DESCENDING(DESCENDING)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (sif.clear),
      .insert     (accept),
      .shift      (consume),
      .new_entry  (new_entry),
      .prev_entry (prev_e),
      .prev_keep  (prev_k),
      .next_entry (next_e),
      .entry      (cell_entry[i]),
      .keep_c     (cell_keep_c[i])
    );
  end

endmodule

// File: doc/insertion_sorter.md
INSERTION_SORTER -- requirements
Module: insertion_sorter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the width of each symbol count.
REQ-002 Parameter ADDR_WIDTH, default 4, is the width of each symbol address.
REQ-003 Parameter DEPTH, default 10, is the number of sort cells and therefore the maximum number of entries held.
REQ-004 Parameter DESCENDING, default 1, selects order: 1 puts the largest count at the head, 0 puts the smallest count at the head.
REQ-005 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  is the asynchronous, active-low reset.
REQ-007 clear  input  1  is a synchronous flush of all entries.
REQ-008 in_valid  input  1  marks a presented entry.
REQ-009 in_ready  output  1  indicates the block accepts an entry this cycle.
REQ-010 in_count  input  DATA_WIDTH  is the key of the presented entry.
REQ-011 in_addr  input  ADDR_WIDTH  is the payload of the presented entry.
REQ-012 drain_req  input  1  is a one-cycle pulse that requests readout.
REQ-013 out_valid  output  1  indicates the head entry is presented.
REQ-014 out_ready  input  1  indicates the sink consumes the head entry.
REQ-015 out_count  output  DATA_WIDTH  is the head key.
REQ-016 out_addr  output  ADDR_WIDTH  is the head payload.
REQ-017 occupancy  output  $clog2(DEPTH+1)  is the number of stored entries.
REQ-018 full and empty  outputs  1 each  are asserted when occupancy equals DEPTH and when occupancy equals 0, respectively.

Function
REQ-019 The block SHALL have two states, FILL and DRAIN, and SHALL enter FILL from reset.
REQ-020 In FILL, in_ready SHALL equal !full; in DRAIN, in_ready SHALL be 0.
REQ-021 An entry is accepted when in_valid and in_ready are both 1, and it SHALL be inserted in sorted position at that clock edge (latency 1 cycle; the entry is visible in occupancy on the next cycle).
REQ-022 Insertion SHALL be stable: a new entry is placed after every stored entry with an equal count.
REQ-023 On insertion, each cell i SHALL:
 - keep its entry if its stored entry precedes or ties the new entry;
 - otherwise take the new entry if cell i-1 kept its entry or i=0;
 - otherwise take cell i-1's entry.
REQ-024 Empty cells SHALL never precede a valid entry.
REQ-025 A drain_req pulse in FILL with occupancy>0 SHALL move the block to DRAIN on the next edge.
REQ-026 A drain_req pulse in FILL with occupancy=0 SHALL be ignored.
REQ-027 If drain_req and an accepted entry occur in the same cycle, the entry SHALL be inserted and the state SHALL move to DRAIN.
REQ-028 In DRAIN, out_valid SHALL be asserted combinationally from the head cell's valid bit; out_count and out_addr SHALL be driven from the head cell.
REQ-029 In DRAIN, each out_valid and out_ready cycle SHALL shift every cell one position toward the head and invalidate the tail cell.
REQ-030 When the final entry is consumed, the block SHALL return to FILL on the same edge.
REQ-031 out_valid SHALL be 0 in FILL.
REQ-032 out_count and out_addr SHALL be 0 whenever out_valid is 0.
REQ-033 An accepted entry while full SHALL be impossible, because in_ready is 0 when full.
REQ-034 drain_req in DRAIN SHALL be ignored.
REQ-035 clear SHALL invalidate all cells and force FILL at the next edge, with priority over insert, drain and shift.
REQ-036 Comparisons SHALL be unsigned over the full DATA_WIDTH.

Reset
REQ-037 While rst_n=0, all cell valid bits, keys, payloads and occupancy SHALL be 0, the state SHALL be FILL, in_ready SHALL be 1, and out_valid SHALL be 0.
REQ-038 Reset asserted mid-insert or mid-drain SHALL discard all contents immediately.
REQ-039 After rst_n deasserts, the first accepted entry SHALL be taken on the first rising edge.

Structure
REQ-040 The state encoding (FILL, DRAIN) and the cell-entry record (valid, count, addr) SHALL reside in the shared package sort_pkg.
REQ-041 Each position SHALL be one instance of the sub-module sort_cell, which holds one entry and produces a keep/insert/shift decision from its own entry, the new entry and its upstream neighbour.
REQ-042 The top level SHALL contain the FSM, the occupancy counter and a generate loop of DEPTH sort_cell instances.

Verification
REQ-043 Insert the counts 5, 9, 2, 9, 7 with addrs 0..4 (DESCENDING=1), then drain with out_ready=1 -> output pairs (9,1), (9,3), (7,4), (5,0), (2,2), then empty=1 and state FILL.
REQ-044 Repeat with DESCENDING=0 -> output order (2,2), (5,0), (7,4), (9,1), (9,3).
REQ-045 Insert 10 entries -> full=1 and in_ready=0; an 11th in_valid is not accepted and occupancy stays at 10.
REQ-046 Issue drain_req with an accept in the same cycle while 3 entries are stored -> 4 entries are drained, and in_ready=0 throughout DRAIN.
REQ-047 Toggle out_ready 1,0,1,0 during a drain -> the head entry is held stable while out_ready=0, and no entry is lost or duplicated.
REQ-048 Assert clear, or pulse rst_n low, in the middle of a drain -> occupancy=0, out_valid=0 and FILL on the next cycle; a subsequent single insert of (3,A) drains as (3,A).
